// File: rtl/sramlike_pkg.sv
// Shared types and constants for the SRAM-style to SRAM-like bus bridges.
package sramlike_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  // kseg0 and kseg1 both have 2'b10 in the top two address bits.
  function automatic logic [31:0] kseg_map(input logic [31:0] vaddr);
    return (vaddr[31:30] == 2'b10) ? (vaddr & KSEG_MASK) : vaddr;
  endfunction

endpackage

// File: rtl/d_sram_to_sramlike_if.sv
// SRAM-like bus: req/addr_ok address phase followed by a data_ok data phase.
interface d_sram_to_sramlike_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              data_data_ok;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    input  data_addr_ok,
    input  data_rdata,
    input  data_data_ok
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    output data_addr_ok,
    output data_rdata,
    output data_data_ok
  );

endinterface

// File: rtl/sramlike_size_enc.sv
// Byte-lane select to SRAM-like transfer size. Purely combinational.
module sramlike_size_enc
  import sramlike_pkg::*;
(
  input  logic [3:0] sel,
  output logic [1:0] size
);

  // Misaligned patterns never reach the bus, so they simply fall back to word.
  always_comb begin
    size = SIZE_WORD;
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      default:                            size = SIZE_WORD;
    endcase
  end

endmodule

// File: rtl/d_sram_to_sramlike.sv
// Data-side bridge: one core SRAM-port access -> one SRAM-like bus transaction.
// Optional D_KSEG_MAP_EN: fold kseg0/kseg1 addresses onto physical space.
module d_sram_to_sramlike
  import sramlike_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_sram_en,
  input  logic [3:0]          data_sram_wen,
  input  logic [3:0]          data_sram_sel,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic                d_stall,
  input  logic                longest_stall,
  d_sram_to_sramlike_if.master bus
);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_WAIT = S_WAIT;
  localparam logic [1:0] ST_DONE = S_DONE;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              req;
  logic              is_write;
  logic [1:0]        size;

  sramlike_size_enc u_size_enc (
    .sel  (data_sram_sel),
    .size (size)
  );

  assign is_write = |data_sram_wen;

  // Request only from IDLE, so a finished access cannot be reissued while
  // the rest of the pipeline is still held.
  assign req     = data_sram_en & (state_q == ST_IDLE);
  assign d_stall = data_sram_en & (state_q != ST_DONE);

  assign bus.data_req   = req;
  assign bus.data_wr    = is_write;
  assign bus.data_size  = size;
  assign bus.data_wdata = data_sram_wdata;

`ifdef D_KSEG_MAP_EN
  assign bus.data_addr = ADDR_W'(kseg_map(32'(data_sram_addr)));
`else
  assign bus.data_addr = data_sram_addr;
`endif

  assign data_sram_rdata = rdata_q;

  // A flush in WAIT still runs to DONE: the bus has no way to abort.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req && bus.data_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.data_data_ok) begin
          state_d = ST_DONE;
          if (!is_write) begin
            rdata_d = bus.data_rdata;
          end
        end
      end
      ST_DONE: begin
        if (!longest_stall) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_d_sram_to_sramlike.sv
// Directed, table-driven bench for d_sram_to_sramlike plus a reset-in-WAIT sequence.
module tb_d_sram_to_sramlike;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        aok;
  logic        dok;
  logic [31:0] brd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  d_sram_to_sramlike_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  assign bus.data_addr_ok = aok;
  assign bus.data_data_ok = dok;
  assign bus.data_rdata   = brd;

  d_sram_to_sramlike #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_sel   (sel),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .bus             (bus.master)
  );

  localparam logic [31:0] A_RD = 32'h8000_0010;
  localparam logic [31:0] A_K  = 32'hBFC0_0100;
`ifdef D_KSEG_MAP_EN
  localparam logic [31:0] A_RD_E = 32'h0000_0010;
  localparam logic [31:0] A_K_E  = 32'h1FC0_0100;
`else
  localparam logic [31:0] A_RD_E = 32'h8000_0010;
  localparam logic [31:0] A_K_E  = 32'hBFC0_0100;
`endif
  localparam logic [31:0] A_ST = 32'h0000_1002;
  localparam logic [31:0] WD   = 32'h00AB_0000;
  localparam logic [31:0] A_H  = 32'h0000_2002;
  localparam logic [31:0] A_R  = 32'h0000_3000;
  localparam logic [31:0] A_S  = 32'h0000_0040;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aok;
    logic        dok;
    logic [31:0] brd;
    logic        ls;
    logic        ereq;
    logic        ewr;
    logic [1:0]  esize;
    logic [31:0] eaddr;
    logic        estall;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic en, input logic [3:0] wen, input logic [3:0] sel,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic aok, input logic dok, input logic [31:0] brd, input logic ls,
    input logic ereq, input logic ewr, input logic [1:0] esize,
    input logic [31:0] eaddr, input logic estall, input logic [31:0] erd);
    vec_t v;
    v.en = en; v.wen = wen; v.sel = sel; v.addr = addr; v.wdata = wdata;
    v.aok = aok; v.dok = dok; v.brd = brd; v.ls = ls;
    v.ereq = ereq; v.ewr = ewr; v.esize = esize; v.eaddr = eaddr;
    v.estall = estall; v.erd = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    en = 1'b0; wen = 4'h0; sel = 4'hF; addr = 32'h0; wdata = 32'h0;
    aok = 1'b0; dok = 1'b0; brd = 32'h0; longest_stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // Read word: addr_ok at once, data_ok next cycle
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_RD,32'h0, 1'b1,1'b0,32'h0,1'b0,        1'b1,1'b0,2'd2,A_RD_E,1'b1,32'h0));
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_RD,32'h0, 1'b0,1'b1,32'hDEADBEEF,1'b0, 1'b0,1'b0,2'd2,A_RD_E,1'b1,32'h0));
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_RD,32'h0, 1'b0,1'b0,32'h0,1'b0,        1'b0,1'b0,2'd2,A_RD_E,1'b0,32'hDEADBEEF));
    vecs.push_back(mk(1'b0,4'h0,4'hF,A_RD,32'h0, 1'b0,1'b0,32'h0,1'b0,        1'b0,1'b0,2'd2,A_RD_E,1'b0,32'hDEADBEEF));
    // Store byte, addr_ok delayed three cycles; write data_ok must not load rdata
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b1,4'h4,4'h4,A_ST,WD, 1'b0,1'b0,32'h0,1'b1,     1'b1,1'b1,2'd0,A_ST,1'b1,32'hDEADBEEF));
    vecs.push_back(mk(1'b1,4'h4,4'h4,A_ST,WD, 1'b1,1'b0,32'h0,1'b1,         1'b1,1'b1,2'd0,A_ST,1'b1,32'hDEADBEEF));
    vecs.push_back(mk(1'b1,4'h4,4'h4,A_ST,WD, 1'b0,1'b1,32'h12345678,1'b1,  1'b0,1'b1,2'd0,A_ST,1'b1,32'hDEADBEEF));
    vecs.push_back(mk(1'b1,4'h4,4'h4,A_ST,WD, 1'b0,1'b0,32'h0,1'b0,         1'b0,1'b1,2'd0,A_ST,1'b0,32'hDEADBEEF));
    vecs.push_back(mk(1'b0,4'h0,4'hF,32'h0,32'h0, 1'b0,1'b0,32'h0,1'b0,     1'b0,1'b0,2'd2,32'h0,1'b0,32'hDEADBEEF));
    // Half read, pipeline held elsewhere for five extra cycles in DONE
    vecs.push_back(mk(1'b1,4'h0,4'hC,A_H,32'h0, 1'b1,1'b0,32'h0,1'b1,       1'b1,1'b0,2'd1,A_H,1'b1,32'hDEADBEEF));
    vecs.push_back(mk(1'b1,4'h0,4'hC,A_H,32'h0, 1'b0,1'b1,32'hCAFE0000,1'b1,1'b0,1'b0,2'd1,A_H,1'b1,32'hDEADBEEF));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1'b1,4'h0,4'hC,A_H,32'h0, 1'b1,1'b1,32'h55555555,1'b1, 1'b0,1'b0,2'd1,A_H,1'b0,32'hCAFE0000));
    vecs.push_back(mk(1'b1,4'h0,4'hC,A_H,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b0,1'b0,2'd1,A_H,1'b0,32'hCAFE0000));
    vecs.push_back(mk(1'b0,4'h0,4'hF,32'h0,32'h0, 1'b0,1'b0,32'h0,1'b0,     1'b0,1'b0,2'd2,32'h0,1'b0,32'hCAFE0000));
    // Stray data_ok in IDLE
    vecs.push_back(mk(1'b0,4'h0,4'hF,32'h0,32'h0, 1'b0,1'b1,32'h11111111,1'b0, 1'b0,1'b0,2'd2,32'h0,1'b0,32'hCAFE0000));
    vecs.push_back(mk(1'b0,4'h0,4'hF,32'h0,32'h0, 1'b0,1'b0,32'h0,1'b0,     1'b0,1'b0,2'd2,32'h0,1'b0,32'hCAFE0000));
    // Flush while in WAIT: access still completes; then new request, then flush in IDLE
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_R,32'h0, 1'b1,1'b0,32'h0,1'b1,       1'b1,1'b0,2'd2,A_R,1'b1,32'hCAFE0000));
    vecs.push_back(mk(1'b0,4'h0,4'hF,A_R,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b0,1'b0,2'd2,A_R,1'b0,32'hCAFE0000));
    vecs.push_back(mk(1'b0,4'h0,4'hF,A_R,32'h0, 1'b0,1'b1,32'h0BADF00D,1'b0,1'b0,1'b0,2'd2,A_R,1'b0,32'hCAFE0000));
    vecs.push_back(mk(1'b0,4'h0,4'hF,A_R,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b0,1'b0,2'd2,A_R,1'b0,32'h0BADF00D));
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_R,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b1,1'b0,2'd2,A_R,1'b1,32'h0BADF00D));
    vecs.push_back(mk(1'b0,4'h0,4'hF,A_R,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b0,1'b0,2'd2,A_R,1'b0,32'h0BADF00D));
    // kseg1 address
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_K,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b1,1'b0,2'd2,A_K_E,1'b1,32'h0BADF00D));
    vecs.push_back(mk(1'b0,4'h0,4'hF,A_K,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b0,1'b0,2'd2,A_K_E,1'b0,32'h0BADF00D));
    // Illegal data_ok with addr_ok is not consumed
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_R,32'h0, 1'b1,1'b1,32'h77777777,1'b1,1'b1,1'b0,2'd2,A_R,1'b1,32'h0BADF00D));
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_R,32'h0, 1'b0,1'b0,32'h0,1'b1,       1'b0,1'b0,2'd2,A_R,1'b1,32'h0BADF00D));
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_R,32'h0, 1'b0,1'b1,32'h600DCAFE,1'b1,1'b0,1'b0,2'd2,A_R,1'b1,32'h0BADF00D));
    vecs.push_back(mk(1'b1,4'h0,4'hF,A_R,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b0,1'b0,2'd2,A_R,1'b0,32'h600DCAFE));
    vecs.push_back(mk(1'b0,4'h0,4'hF,A_R,32'h0, 1'b0,1'b0,32'h0,1'b0,       1'b0,1'b0,2'd2,A_R,1'b0,32'h600DCAFE));
    // Size/wr decode with no request
    vecs.push_back(mk(1'b0,4'h1,4'h1,A_S,32'h0, 1'b0,1'b0,32'h0,1'b0, 1'b0,1'b1,2'd0,A_S,1'b0,32'h600DCAFE));
    vecs.push_back(mk(1'b0,4'h2,4'h2,A_S,32'h0, 1'b0,1'b0,32'h0,1'b0, 1'b0,1'b1,2'd0,A_S,1'b0,32'h600DCAFE));
    vecs.push_back(mk(1'b0,4'h8,4'h8,A_S,32'h0, 1'b0,1'b0,32'h0,1'b0, 1'b0,1'b1,2'd0,A_S,1'b0,32'h600DCAFE));
    vecs.push_back(mk(1'b0,4'h3,4'h3,A_S,32'h0, 1'b0,1'b0,32'h0,1'b0, 1'b0,1'b1,2'd1,A_S,1'b0,32'h600DCAFE));
    vecs.push_back(mk(1'b0,4'h6,4'h6,A_S,32'h0, 1'b0,1'b0,32'h0,1'b0, 1'b0,1'b1,2'd2,A_S,1'b0,32'h600DCAFE));
    vecs.push_back(mk(1'b0,4'h0,4'h0,A_S,32'h0, 1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,2'd2,A_S,1'b0,32'h600DCAFE));

    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.req",   32'(bus.data_req), 32'h0);
    check("reset.stall", 32'(d_stall),      32'h0);
    check("reset.rdata", rdata,             32'h0);
    $display("[TB] reset req=%b stall=%b rdata=%h", bus.data_req, d_stall, rdata);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      en = vecs[i].en; wen = vecs[i].wen; sel = vecs[i].sel;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      aok = vecs[i].aok; dok = vecs[i].dok; brd = vecs[i].brd;
      longest_stall = vecs[i].ls;
      #1;
      check($sformatf("v%0d.req",   i), 32'(bus.data_req),  32'(vecs[i].ereq));
      check($sformatf("v%0d.wr",    i), 32'(bus.data_wr),   32'(vecs[i].ewr));
      check($sformatf("v%0d.size",  i), 32'(bus.data_size), 32'(vecs[i].esize));
      check($sformatf("v%0d.addr",  i), bus.data_addr,      vecs[i].eaddr);
      check($sformatf("v%0d.wdata", i), bus.data_wdata,     vecs[i].wdata);
      check($sformatf("v%0d.stall", i), 32'(d_stall),       32'(vecs[i].estall));
      check($sformatf("v%0d.rdata", i), rdata,              vecs[i].erd);
      $display("[TB] v%0d en=%b req=%b wr=%b size=%0d addr=%h stall=%b rdata=%h",
               i, en, bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, d_stall, rdata);
    end

    // Reset while in WAIT, followed by a stray data_ok
    @(negedge clk);
    en = 1'b1; wen = 4'h0; sel = 4'hF; addr = A_R; aok = 1'b1; dok = 1'b0; longest_stall = 1'b1;
    #1;
    check("rstwait.req0", 32'(bus.data_req), 32'h1);
    @(negedge clk);
    aok = 1'b0;
    #1;
    check("rstwait.wait_req",   32'(bus.data_req), 32'h0);
    check("rstwait.wait_stall", 32'(d_stall),      32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; dok = 1'b1; brd = 32'hFFFF_FFFF;
    #1;
    check("rstwait.rdata", rdata,             32'h0);
    check("rstwait.req",   32'(bus.data_req), 32'h0);
    check("rstwait.stall", 32'(d_stall),      32'h0);
    @(negedge clk);
    dok = 1'b0; en = 1'b1; longest_stall = 1'b0;
    #1;
    check("rstwait.stray_rdata", rdata,             32'h0);
    check("rstwait.idle_req",    32'(bus.data_req), 32'h1);
    $display("[TB] rst-in-wait req=%b stall=%b rdata=%h", bus.data_req, d_stall, rdata);
    @(negedge clk);
    drive_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
